uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100000000, input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, line bit rate in bit/s.
REQ-003 The block SHALL have parameter STOP_BITS, default 1, number of stop bits (legal values 1 and 2).
REQ-004 The block SHALL have port CLK, input, 1, the only clock; all logic is rising-edge.
REQ-005 The block SHALL have port RST, input, 1, reset; synchronous, active-high.
REQ-006 The block SHALL have port TX_DATA, input, 8, the byte to send; sampled only on handshake.
REQ-007 The block SHALL have port TX_VALID, input, 1, the requester offers TX_DATA.
REQ-008 The block SHALL have port TX_READY, output, 1, the block accepts a byte this cycle.
REQ-009 The block SHALL have port TX_BUSY, output, 1, high while a frame is on the line.
REQ-010 The block SHALL have port UART_TX, output, 1, serial line, idle high; registered.

Function
REQ-011 Bit period SHALL be DIV = CLK_FREQ/BAUD cycles (integer truncation); 100 MHz/115200 gives 868.
REQ-012 States SHALL be IDLE, START, DATA, PARITY (macro only), and STOP.
REQ-013 TX_READY SHALL equal (state==IDLE) and not RST; handshake = TX_VALID and TX_READY.
REQ-014 On handshake, TX_DATA SHALL be latched, the baud counter cleared, and the state set to START; UART_TX goes low on the next edge (1-cycle latency).
REQ-015 START SHALL hold UART_TX=0 for DIV cycles, then go to DATA.
REQ-016 DATA SHALL shift 8 bits LSB first, DIV cycles each, using a 3-bit index that wraps from 7 to leave DATA.
REQ-017 STOP SHALL hold UART_TX=1 for STOP_BITS*DIV cycles, then return to IDLE.
REQ-018 Back-to-back: a handshake in the first IDLE cycle after STOP SHALL start the next start bit the following edge; the minimum gap is 1 idle-high cycle.
REQ-019 TX_DATA/TX_VALID changes while not IDLE SHALL be ignored, and the latched byte is unaffected.
REQ-020 TX_BUSY SHALL be high in every state except IDLE.
REQ-021 The baud counter SHALL be a wrap-free down or up counter sized as clog2(DIV); terminal count advances the bit and reloads.

Reset
REQ-022 With RST high at an edge, the following SHALL hold next cycle: state=IDLE, UART_TX=1, TX_BUSY=0, counters and bit index 0, shift register 0.
REQ-023 RST mid-frame SHALL abort the frame immediately, with no stop bit emitted; the line is held high.
REQ-024 While RST is high, TX_READY SHALL be 0 and TX_VALID is ignored.

Configuration
REQ-025 Macro UART_TX_PARITY_EN SHALL, when defined, insert a PARITY state between DATA and STOP, lasting DIV cycles and carrying even parity (XOR of the 8 data bits).
REQ-026 Without UART_TX_PARITY_EN, DATA SHALL go directly to STOP, and no parity logic is synthesized; the frame is 10 bits for STOP_BITS=1.

Structure
REQ-027 Package uart_pkg SHALL hold the state encoding (3-bit), the DIV computation function, and the DATA_W=8 constant, so a future uart_rx can share them.
REQ-028 Sub-module uart_baud_gen SHALL produce a 1-cycle tick every DIV cycles, with a synchronous clear input driven by the handshake.
REQ-029 The remaining logic (FSM, shifter, output register) SHALL sit in uart_tx.

Verification
REQ-030 Test: defaults, send 0x55 -> UART_TX = 0,1,0,1,0,1,0,1,0,1, each bit 868 cycles, total 8680 cycles, then TX_READY=1.
REQ-031 Test: send 0xA3 then 0x0F with TX_VALID held high -> second start bit begins 1 cycle after first stop ends; TX_READY pulses for exactly 1 cycle between frames.
REQ-032 Test: UART_TX_PARITY_EN, send 0x07 -> parity bit 1; send 0x55 -> parity bit 0; frame 11*868 cycles.
REQ-033 Test: assert RST for 1 cycle at the 4th data bit -> UART_TX=1 next cycle, TX_BUSY=0; a new byte 0xFF then sends a clean frame.
REQ-034 Test: STOP_BITS=2, send 0x00 -> line low 9*868 cycles, high 1736 cycles before TX_READY=1.
REQ-035 Test: change TX_DATA to 0xFF mid-frame of 0x81 -> line still carries 0x81.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, bit-period helper and data width shared by the UART blocks
package uart_pkg;
  localparam int DATA_W = 8;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: one-cycle tick every DIV clocks, restartable by a synchronous clear
module uart_baud_gen #(
  parameter int DIV = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 UART transmitter with valid/ready byte input and registered line output
// Define UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit(s).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD      = 115200,
  parameter int STOP_BITS = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  output logic              TX_BUSY,
  output logic              UART_TX
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  state_t state, state_d;
  logic [2:0] idx, idx_d;
  logic [DATA_W-1:0] shift, shift_d;
  logic tick, hs, line_d;
  assign TX_READY = state == IDLE && !RST;
  assign TX_BUSY  = state != IDLE;
  assign hs       = TX_VALID && TX_READY;
  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk (CLK),
    .rst (RST),
    .clr (hs),
    .tick(tick)
  );
`ifdef UART_TX_PARITY_EN
  logic par;
  always_ff @(posedge CLK)
    if (RST) par <= 1'b0;
    else if (hs) par <= ^TX_DATA;
`endif
  always_comb begin
    state_d = state;
    idx_d   = idx;
    shift_d = shift;
    case (state)
      IDLE:
        if (hs) begin
          state_d = START;
          shift_d = TX_DATA;
        end
      START:
        if (tick) begin
          state_d = DATA;
          idx_d   = '0;
        end
      DATA:
        if (tick) begin
          idx_d   = idx + 3'd1;
          shift_d = shift >> 1;
`ifdef UART_TX_PARITY_EN
          if (idx == 3'd7) state_d = PARITY;
`else
          if (idx == 3'd7) state_d = STOP;
`endif
        end
`ifdef UART_TX_PARITY_EN
      PARITY:
        if (tick) state_d = STOP;
`endif
      STOP:
        if (tick) begin
          if (idx == 3'(STOP_BITS - 1)) begin
            state_d = IDLE;
            idx_d   = '0;
          end else idx_d = idx + 3'd1;
        end
      default: state_d = IDLE;
    endcase
    // line is registered from the next state so the start bit appears one edge after handshake
`ifdef UART_TX_PARITY_EN
    line_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par : 1'b1;
`else
    line_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
`endif
  end
  always_ff @(posedge CLK)
    if (RST) begin
      state   <= IDLE;
      idx     <= '0;
      shift   <= '0;
      UART_TX <= 1'b1;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      shift   <= shift_d;
      UART_TX <= line_d;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: frame-level checks of uart_tx with 1 and 2 stop bits against an expected line waveform
module tb_uart_tx;
  localparam int CF  = 1000;
  localparam int BD  = 120;
  localparam int DIV = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif
  typedef struct {
    logic [7:0] d;
    logic [9:0] fb;
    logic       par;
    int         sb;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0][7:0] d;
  logic [1:0] v, rdy, busy, line;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  uart_tx #(.CLK_FREQ(CF), .BAUD(BD), .STOP_BITS(1)) dut_a (
    .CLK(clk), .RST(rst), .TX_DATA(d[0]), .TX_VALID(v[0]),
    .TX_READY(rdy[0]), .TX_BUSY(busy[0]), .UART_TX(line[0])
  );
  uart_tx #(.CLK_FREQ(CF), .BAUD(BD), .STOP_BITS(2)) dut_b (
    .CLK(clk), .RST(rst), .TX_DATA(d[1]), .TX_VALID(v[1]),
    .TX_READY(rdy[1]), .TX_BUSY(busy[1]), .UART_TX(line[1])
  );
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic logic exp_line(input int k, input logic [9:0] fb, input logic par);
    int p = k / DIV;
    if (p < 9) return fb[p];
    if (PEN == 1 && p == 9) return par;
    return 1'b1;
  endfunction
  task automatic launch(input int w, input logic [7:0] dat, input logic hold, input logic [7:0] nxt,
                        input string nm);
    int n = 0;
    @(negedge clk);
    while (!rdy[w] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_ready"}, int'(rdy[w]), 1);
    d[w] = dat;
    v[w] = 1'b1;
    @(posedge clk);
    #1;
    v[w] = hold;
    d[w] = nxt;
  endtask
  // Samples every cycle of the frame; while not holding, TX_DATA/TX_VALID are scrambled to prove they are ignored.
  task automatic run_frame(input int w, input logic [9:0] fb, input logic par, input int sb,
                           input logic hold, input string nm);
    int len = DIV * (9 + PEN + sb);
    int errs = 0;
    int first = -1;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (line[w] !== exp_line(k, fb, par) || busy[w] !== 1'b1 || rdy[w] !== 1'b0) begin
        errs++;
        if (first < 0) first = k;
      end
      if (!hold) begin
        d[w] = 8'($urandom);
        v[w] = k < len - 1 ? 1'($urandom) : 1'b0;
      end
    end
    if (errs != 0) $display("%s: first wrong cycle %0d", nm, first);
    chk({nm, "_bad_cycles"}, errs, 0);
    @(negedge clk);
    chk({nm, "_idle"}, int'({rdy[w], busy[w], line[w]}), 3'b101);
  endtask
  initial begin
    vec_t tbl[8];
    int lows;
    logic [7:0] r;
    int w;
    tbl = '{
      '{8'h55, 10'b1010101010, 1'b0, 1},
      '{8'hA3, 10'b1101000110, 1'b0, 1},
      '{8'h07, 10'b1000001110, 1'b1, 1},
      '{8'h81, 10'b1100000010, 1'b0, 1},
      '{8'hFF, 10'b1111111110, 1'b0, 1},
      '{8'h00, 10'b1000000000, 1'b0, 2},
      '{8'h0F, 10'b1000011110, 1'b0, 2},
      '{8'h07, 10'b1000001110, 1'b1, 2}
    };
    d = '0;
    v = 2'b11;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(rdy), 0);
    chk("rst_line", int'(line), 3);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    v = 2'b00;
    @(negedge clk);
    chk("post_rst", int'({rdy, busy, line}), 6'b110011);
    foreach (tbl[i]) begin
      w = tbl[i].sb - 1;
      launch(w, tbl[i].d, 1'b0, 8'hFF, $sformatf("tbl%0d", i));
      run_frame(w, tbl[i].fb, tbl[i].par, tbl[i].sb, 1'b0, $sformatf("tbl%0d", i));
    end
    launch(0, 8'hA3, 1'b1, 8'h0F, "b2b_a3");
    run_frame(0, 10'b1101000110, 1'b0, 1, 1'b1, "b2b_a3");
    @(posedge clk);
    #1;
    v[0] = 1'b0;
    run_frame(0, 10'b1000011110, 1'b0, 1, 1'b0, "b2b_0f");
    launch(0, 8'h55, 1'b0, 8'h00, "abort");
    repeat (DIV * 4 + DIV / 2) @(negedge clk);
    chk("abort_mid_bit3", int'(line[0]), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle", int'({rdy[0], busy[0], line[0]}), 3'b101);
    lows = 0;
    repeat (DIV * 8) begin
      @(negedge clk);
      if (line[0] !== 1'b1 || busy[0] !== 1'b0) lows++;
    end
    chk("abort_quiet", lows, 0);
    launch(0, 8'hFF, 1'b0, 8'h00, "after_abort");
    run_frame(0, 10'b1111111110, 1'b0, 1, 1'b0, "after_abort");
    repeat (8) begin
      r = 8'($urandom);
      w = int'($urandom_range(1, 0));
      launch(w, r, 1'b0, ~r, $sformatf("rnd_%02h", r));
      run_frame(w, {1'b1, r, 1'b0}, ^r, w + 1, 1'b0, $sformatf("rnd_%02h", r));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, bad=%0d", bad);
    $fatal(1);
  end
endmodule
